// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//
// Stall and multi-cycle sequencing controller for the five-stage mips
// pipeline. Merges load-use stall requests from ID and multi-cycle requests
// from EX into a single per-stage stall vector. It also sequences the EX
// iterative divider (start pulse, iteration index, completion strobe) and
// the two-cycle multiply-accumulate.
//
// Parameters
//   DIV_CYCLES        divider iterations after the start cycle (1..63)
//
// Ports
//   clock             single clock, rising edge active
//   reset             synchronous, active-high
//   id_stall_request  ID cannot issue this cycle (load-use hazard)
//   ex_multi_request  instruction in EX is multi-cycle (held while in EX)
//   ex_multi_kind     0 = multiply-accumulate, 1 = divide
//   ex_multi_cancel   divider early termination (divisor zero)
//   stall[5:0]        per-stage hold bits: pc, if/id, id, ex, mem, wb
//   div_start         one-cycle pulse: divider loads operands
//   div_index[5:0]    current divider iteration, 0 outside DIV
//   multi_done        EX result of the multi-cycle op is valid this cycle
//
// Outputs are Mealy (combinational from state, counter and inputs) so a
// stall takes effect in the same cycle it is requested.

module pipeline_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       id_stall_request,
    input  logic       ex_multi_request,
    input  logic       ex_multi_kind,
    input  logic       ex_multi_cancel,
    output logic [5:0] stall,
    output logic       div_start,
    output logic [5:0] div_index,
    output logic       multi_done
);

    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] LAST_ITER  = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;

    logic [5:0] id_or_none;

    // Stall pattern used whenever EX is not holding the pipeline.
    assign id_or_none = id_stall_request ? STALL_ID : STALL_NONE;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall      = STALL_NONE;
        div_start  = 1'b0;
        div_index  = 6'd0;
        multi_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_multi_request) begin
                    // EX-origin stall wins outright over any ID request.
                    stall = STALL_EX;
                    if (!ex_multi_kind) begin
                        state_d = ACC;
                    end else if (!ex_multi_cancel) begin
                        div_start = 1'b1;
                        cnt_d     = 6'd0;
                        state_d   = DIV;
                    end else begin
                        // Divisor zero: skip the iterations entirely.
                        state_d = DONE;
                    end
                end else begin
                    stall = id_or_none;
                end
            end
            ACC: begin
                multi_done = 1'b1;
                stall      = id_or_none;
                state_d    = IDLE;
            end
            DIV: begin
                stall     = STALL_EX;
                div_index = cnt_q;
                // Counter saturates on the last iteration so it never wraps.
                if ((cnt_q == LAST_ITER) || ex_multi_cancel) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                multi_done = 1'b1;
                stall      = id_or_none;
                cnt_d      = 6'd0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        // Reset cycle: all outputs quiet regardless of state or inputs,
        // which also aborts an in-flight divide without a completion strobe.
        if (reset) begin
            stall      = STALL_NONE;
            div_start  = 1'b0;
            div_index  = 6'd0;
            multi_done = 1'b0;
            state_d    = IDLE;
            cnt_d      = 6'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed testbench for pipeline_ctrl (DIV_CYCLES = 32). Each step drives
// one cycle of inputs, pushes the expected Mealy outputs onto a scoreboard
// queue, then pops and compares them on the falling edge of that cycle.

module tb_pipeline_ctrl;

    localparam logic [5:0] S_EX = 6'b001111;
    localparam logic [5:0] S_ID = 6'b000111;
    localparam logic [5:0] S_NO = 6'b000000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       id_stall_request = 1'b0;
    logic       ex_multi_request = 1'b0;
    logic       ex_multi_kind = 1'b0;
    logic       ex_multi_cancel = 1'b0;
    logic [5:0] stall;
    logic       div_start;
    logic [5:0] div_index;
    logic       multi_done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0] stall;
        logic       start;
        logic [5:0] idx;
        logic       done;
        string      tag;
    } exp_t;

    exp_t sb[$];

    pipeline_ctrl #(.DIV_CYCLES(32)) dut (
        .clock            (clock),
        .reset            (reset),
        .id_stall_request (id_stall_request),
        .ex_multi_request (ex_multi_request),
        .ex_multi_kind    (ex_multi_kind),
        .ex_multi_cancel  (ex_multi_cancel),
        .stall            (stall),
        .div_start        (div_start),
        .div_index        (div_index),
        .multi_done       (multi_done)
    );

    always #5 clock = ~clock;

    task automatic check_outputs();
        exp_t e;
        total++;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty got=%0d exp=>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            assert (stall === e.stall) else begin
                bad++;
                $error("FAIL %s stall got=%b exp=%b", e.tag, stall, e.stall);
            end
            total++;
            assert (div_start === e.start) else begin
                bad++;
                $error("FAIL %s div_start got=%b exp=%b", e.tag, div_start, e.start);
            end
            total++;
            assert (div_index === e.idx) else begin
                bad++;
                $error("FAIL %s div_index got=%0d exp=%0d", e.tag, div_index, e.idx);
            end
            total++;
            assert (multi_done === e.done) else begin
                bad++;
                $error("FAIL %s multi_done got=%b exp=%b", e.tag, multi_done, e.done);
            end
            $display("step %-12s rst=%b idr=%b req=%b kind=%b cancel=%b -> stall=%b start=%b idx=%0d done=%b",
                     e.tag, reset, id_stall_request, ex_multi_request, ex_multi_kind,
                     ex_multi_cancel, stall, div_start, div_index, multi_done);
        end
    endtask

    // One clock cycle: drive inputs just after the rising edge, record the
    // expectation, compare on the falling edge, then move to the next cycle.
    task automatic cyc(input logic rst, input logic idr, input logic req,
                       input logic kind, input logic cancel,
                       input logic [5:0] e_stall, input logic e_start,
                       input logic [5:0] e_idx, input logic e_done,
                       input string tag);
        exp_t e;
        reset            = rst;
        id_stall_request = idr;
        ex_multi_request = req;
        ex_multi_kind    = kind;
        ex_multi_cancel  = cancel;
        e.stall = e_stall;
        e.start = e_start;
        e.idx   = e_idx;
        e.done  = e_done;
        e.tag   = tag;
        sb.push_back(e);
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        #1;
    endtask

    initial begin
        @(posedge clock);
        #1;

        // Reset held 3 cycles with requests active: all outputs quiet.
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 1, 0, 0, S_NO, 0, 6'd0, 0, "reset_hold");

        // First cycle after release: madd accepted, EX stall overrides ID.
        cyc(0, 1, 1, 0, 0, S_EX, 0, 6'd0, 0, "madd_req");
        cyc(0, 0, 1, 0, 0, S_NO, 0, 6'd0, 1, "madd_acc");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        // ID-origin stall pulse for two cycles.
        cyc(0, 1, 0, 0, 0, S_ID, 0, 6'd0, 0, "id_pulse");
        cyc(0, 1, 0, 0, 0, S_ID, 0, 6'd0, 0, "id_pulse");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "id_release");

        // madd with an ID stall during the ACC cycle.
        cyc(0, 0, 1, 0, 0, S_EX, 0, 6'd0, 0, "madd2_req");
        cyc(0, 1, 1, 0, 0, S_ID, 0, 6'd0, 1, "madd2_acc_id");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        // Full divide: start, 32 iterations (ID stall masked), done.
        cyc(0, 0, 1, 1, 0, S_EX, 1, 6'd0, 0, "div_start");
        for (int i = 0; i < 32; i++)
            cyc(0, i[0], 1, 1, 0, S_EX, 0, 6'(i), 0, "div_iter");
        cyc(0, 0, 1, 1, 0, S_NO, 0, 6'd0, 1, "div_done");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        // Cancel in the request cycle: no start, done next cycle.
        cyc(0, 0, 1, 1, 1, S_EX, 0, 6'd0, 0, "cancel_req");
        cyc(0, 1, 1, 1, 1, S_ID, 0, 6'd0, 1, "cancel_done");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        // Cancel at index 5.
        cyc(0, 0, 1, 1, 0, S_EX, 1, 6'd0, 0, "div5_start");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 1, 1, 0, S_EX, 0, 6'(i), 0, "div5_iter");
        cyc(0, 0, 1, 1, 1, S_EX, 0, 6'd5, 0, "div5_cancel");
        cyc(0, 0, 1, 1, 0, S_NO, 0, 6'd0, 1, "div5_done");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        // Reset mid-divide at index 10 aborts without multi_done.
        cyc(0, 0, 1, 1, 0, S_EX, 1, 6'd0, 0, "div10_start");
        for (int i = 0; i <= 10; i++)
            cyc(0, 0, 1, 1, 0, S_EX, 0, 6'(i), 0, "div10_iter");
        cyc(1, 1, 1, 1, 0, S_NO, 0, 6'd0, 0, "div10_reset");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "post_reset");

        // New divide restarts at index 0; cancel at index 1.
        cyc(0, 0, 1, 1, 0, S_EX, 1, 6'd0, 0, "redo_start");
        cyc(0, 0, 1, 1, 0, S_EX, 0, 6'd0, 0, "redo_iter");
        cyc(0, 0, 1, 1, 1, S_EX, 0, 6'd1, 0, "redo_cancel");
        cyc(0, 0, 1, 1, 0, S_NO, 0, 6'd0, 1, "redo_done");
        cyc(0, 0, 0, 0, 0, S_NO, 0, 6'd0, 0, "idle");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall and multi-cycle sequencing controller for the five-stage `mips` pipeline. It merges stall requests from ID (load-use hazards) and EX (multi-cycle arithmetic) into one per-stage stall vector consumed by `pc_reg` and the four pipeline buffers. It also sequences the EX-stage iterative divider and two-cycle multiply-accumulate: start pulse, iteration index, completion strobe. It sits beside the datapath in `mips`, with inputs from `id`/`ex` and outputs fanned to every stage register.

## Interface

Parameters:

- `DIV_CYCLES`, default 32: divider iterations after the start cycle; legal range 1..63.

Ports:

- `clock`  in  1  — the design's single clock.
- `reset`  in  1  — synchronous, active-high; sampled on the rising edge of `clock`.
- `id_stall_request`  in  1  — ID cannot issue this cycle (load-use hazard).
- `ex_multi_request`  in  1  — the instruction in EX is multi-cycle; held high by EX for as long as that instruction sits in EX.
- `ex_multi_kind`  in  1  — 0 = multiply-accumulate (madd/msub), 1 = divide; valid while `ex_multi_request` is high.
- `ex_multi_cancel`  in  1  — divider early termination (divisor zero); meaningful only for kind 1.
- `stall`  out  6  — per-stage stall bits:
  - bit0 `pc_reg`
  - bit1 `if_id_buffer`
  - bit2 ID / `id_ex_buffer` input
  - bit3 EX / `ex_mem_buffer` input
  - bit4 MEM
  - bit5 WB
- `div_start`  out  1  — one-cycle pulse: divider loads operands.
- `div_index`  out  6  — current divider iteration, 0..`DIV_CYCLES`-1.
- `multi_done`  out  1  — EX result of a multi-cycle op is valid this cycle; EX stall is released this cycle.

## Operation

- States: IDLE, ACC, DIV, DONE. The state and a 6-bit iteration counter are registered. All outputs are combinational from state, counter and inputs (Mealy), so a stall takes effect in the request cycle.
- Stall encoding: a stage whose bit is 1 holds; the first buffer whose input stage stalls while its output stage does not inserts a bubble.
- Stall values:
  - EX-origin stall = 6'b001111.
  - ID-origin stall = 6'b000111.
  - No stall = 6'b000000.
  - EX-origin overrides ID-origin; the two are never OR-merged into another pattern.
- IDLE:
  - `ex_multi_request`=1, kind 0 → stall 001111, next state ACC.
  - `ex_multi_request`=1, kind 1, cancel 0 → `div_start`=1, stall 001111, counter←0, next state DIV.
  - `ex_multi_request`=1, kind 1, cancel 1 → stall 001111, no `div_start`, next state DONE.
  - Otherwise → stall = `id_stall_request` ? 000111 : 000000.
- ACC: `multi_done`=1; EX stall released (stall = ID-origin or 0); next state IDLE.
- DIV:
  - stall 001111; `div_index`=counter.
  - Counter increments each cycle.
  - When counter == `DIV_CYCLES`-1, or `ex_multi_cancel`=1 → next state DONE.
- DONE: `multi_done`=1; EX stall released; next state IDLE.
- In ACC, DIV and DONE, `ex_multi_request` is the same instruction still in EX and is ignored. A new multi-cycle op is accepted only in IDLE.
- `id_stall_request` during ACC or DONE produces 000111 in that cycle. During DIV it is masked by the EX stall.
- Output values outside DIV:
  - `div_index` = 0.
  - `div_start` = 0, except in the IDLE start cycle.
  - `multi_done` = 0, except in ACC and DONE.

## Timing

- Reset: state IDLE, counter 0.
- Reset-cycle outputs:
  - `stall`=0, `div_start`=0, `div_index`=0, `multi_done`=0, regardless of other inputs.
  - Reset during DIV aborts the operation; no `multi_done` is produced.
- Multiply-accumulate: 1 stall cycle (request cycle), then `multi_done` in the next cycle. The instruction leaves EX at the edge ending the ACC cycle.
- Divide: 1 start cycle plus `DIV_CYCLES` DIV cycles with stall 001111, then one DONE cycle. Total EX occupancy is `DIV_CYCLES`+2 cycles.
- Cancel:
  - In the start cycle → DONE on the next cycle; EX occupancy 2 cycles.
  - In DIV at counter k → DONE on the next cycle.
- Counter never exceeds `DIV_CYCLES`-1; no wrap.

## Test plan

- Reset held 3 cycles with `ex_multi_request`=1 and `id_stall_request`=1 → all outputs 0 throughout; IDLE with stall 001111 on the first cycle after release.
- `id_stall_request` pulsed 2 cycles in IDLE → stall 000111 for exactly those 2 cycles, then 000000; `multi_done` stays 0.
- madd: `ex_multi_request`=1, kind 0, held 2 cycles → stall 001111 in cycle 0; cycle 1 stall 000000 and `multi_done`=1; back to IDLE.
- Divide, `DIV_CYCLES`=32:
  - cycle 0: `div_start`=1.
  - cycles 1..32: `div_index` 0..31, stall 001111.
  - cycle 33: `multi_done`=1, stall 0.
  - `id_stall_request`=1 during the DIV cycles still yields 001111.
- Divide cancel: cancel=1 in the request cycle → no `div_start`, next cycle `multi_done`=1. Cancel at `div_index`=5 → DONE in the following cycle.
- Reset asserted at `div_index`=10 → next cycle all outputs 0; a new divide request afterwards restarts at `div_index`=0.
